id_ex_stage: RTL and testbench

ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS pipeline. Captures decoded operands and control from ID each cycle, supports stall (hold) and flush (bubble), and drives the ALU's two operand inputs and the ALU control unit's ALUOp/funct inputs. Sits directly upstream of the ALU and ALU control, and downstream of the register file and main decoder.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 43 ++++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants
// Purpose: ALUOp encodings, zero-register index and the ID/EX control bundle.
// Ports: none (package).
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int REG_ZERO = 0;

    // All-zero value is the bubble: nothing written, no memory access, add.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - single-operand MEM/WB forwarding select
// Purpose: picks MEM result, WB result or register-file data for one operand.
// Ports:
//   i_idx            operand register index
//   i_reg_data       registered register-file data
//   i_mem_reg_write, i_mem_rd, i_mem_result   EX/MEM producer
//   i_wb_reg_write,  i_wb_rd,  i_wb_result    MEM/WB producer
//   o_data           forwarded operand
module fwd_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_mem_reg_write,
    input  logic [REG_W-1:0]  i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_wb_reg_write,
    input  logic [REG_W-1:0]  i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_result,
    output logic [DATA_W-1:0] o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hard-wired, so a producer targeting it never forwards.
    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != REG_W'(REG_ZERO)) && (i_mem_rd == i_idx);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != REG_W'(REG_ZERO)) && (i_wb_rd  == i_idx);

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX operand forwarding
// Purpose: registers decoded operands/controls (stall holds, flush bubbles)
//          and drives ALU operands with MEM/WB forwarding.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall, flush             hold stage / load bubble
//   id_*                     decoded instruction from ID
//   mem_*, wb_*              forwarding sources
//   alu_inn1/2, alu_funct, alu_op      ALU and ALU-control inputs
//   ex_*                     registered stage outputs for downstream stages
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_inn1,
    output logic [DATA_W-1:0] alu_inn2,
    output logic [5:0]        alu_funct,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [DATA_W-1:0] ex_branch_target,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic [REG_W-1:0]  ex_rt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_write_reg;

    ctrl_t             w_id_ctrl;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    assign w_id_ctrl = '{
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        branch:     id_branch,
        alu_src:    id_alu_src,
        reg_dst:    id_reg_dst,
        alu_op:     id_alu_op
    };

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_ctrl      <= CTRL_BUBBLE;
            r_valid     <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_write_reg <= '0;
        end else if (!stall) begin
            r_ctrl      <= w_id_ctrl;
            r_valid     <= 1'b1;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_pc4       <= id_pc4;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            // Destination resolved at capture so EX sees a plain register.
            r_write_reg <= id_reg_dst ? id_rd : id_rt;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_a (
        .i_idx           (r_rs),
        .i_reg_data      (r_rs_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_result    (mem_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_fwd_a)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_b (
        .i_idx           (r_rt),
        .i_reg_data      (r_rt_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_result    (mem_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_fwd_b)
    );

    assign alu_inn1         = w_fwd_a;
    assign alu_inn2         = r_ctrl.alu_src ? r_imm : w_fwd_b;
    // Stores need the real rt value even when the ALU takes the immediate.
    assign ex_store_data    = w_fwd_b;
    assign alu_funct        = r_imm[5:0];
    assign alu_op           = r_ctrl.alu_op;
    assign ex_branch_target = r_pc4 + {r_imm[DATA_W-3:0], 2'b00};
    assign ex_write_reg     = r_write_reg;
    assign ex_rt            = r_rt;
    assign ex_valid         = r_valid;
    assign ex_reg_write     = r_ctrl.reg_write;
    assign ex_mem_read      = r_ctrl.mem_read;
    assign ex_mem_write     = r_ctrl.mem_write;
    assign ex_mem_to_reg    = r_ctrl.mem_to_reg;
    assign ex_branch        = r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read;
    logic        id_mem_write, id_mem_to_reg, id_branch;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] alu_inn1, alu_inn2, ex_store_data, ex_branch_target;
    logic [5:0]  alu_funct;
    logic [1:0]  alu_op;
    logic [4:0]  ex_write_reg, ex_rt;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_inn1(alu_inn1), .alu_inn2(alu_inn2), .alu_funct(alu_funct),
        .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_branch_target(ex_branch_target), .ex_write_reg(ex_write_reg),
        .ex_rt(ex_rt), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_off();
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
        wb_reg_write  = 1'b0; wb_rd  = 5'd0; wb_result  = 32'h0;
    endtask

    task automatic id_ctrl(input logic [1:0] op, input logic src, input logic dst,
                           input logic rw, input logic mr, input logic mw,
                           input logic m2r, input logic br);
        id_alu_op = op; id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        id_rs_data = 32'h1111_1111; id_rt_data = 32'h2222_2222;
        id_imm = 32'h3333_3333; id_pc4 = 32'h4444_4444;
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
        id_ctrl(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'hAAAA_AAAA;
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'hBBBB_BBBB;
        step();
        step();
        fwd_off();
        #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", ex_valid);
        end
        checks++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, alu_op} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, alu_op});
        end
        checks++;
        if (alu_inn1 !== 32'h0 || alu_inn2 !== 32'h0) begin
            failures++; $display("FAIL reset_ops got=%h/%h exp=0/0", alu_inn1, alu_inn2);
        end
        checks++;
        if (ex_branch_target !== 32'h0 || ex_write_reg !== 5'd0 || ex_rt !== 5'd0) begin
            failures++;
            $display("FAIL reset_regs got=%h/%0d/%0d exp=0/0/0", ex_branch_target, ex_write_reg, ex_rt);
        end
        reset = 1'b0; stall = 1'b0;
    endtask

    task automatic test_fwd_priority();
        id_rs = 5'd3; id_rs_data = 32'h10; id_rt = 5'd4; id_rt_data = 32'h20;
        id_rd = 5'd8; id_imm = 32'h0000_0022; id_pc4 = 32'h100;
        id_ctrl(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
        step();
        checks++;
        if (alu_inn1 !== 32'hAA || alu_inn2 !== 32'h20) begin
            failures++; $display("FAIL fwd_mem_prio got=%h/%h exp=aa/20", alu_inn1, alu_inn2);
        end
        checks++;
        if (ex_valid !== 1'b1 || ex_write_reg !== 5'd8 || alu_funct !== 6'h22 || alu_op !== 2'b10) begin
            failures++;
            $display("FAIL fwd_load got=%0b/%0d/%h/%b exp=1/8/22/10", ex_valid, ex_write_reg, alu_funct, alu_op);
        end
        mem_reg_write = 1'b0;
        #1;
        checks++;
        if (alu_inn1 !== 32'hBB) begin
            failures++; $display("FAIL fwd_wb got=%h exp=bb", alu_inn1);
        end
        wb_reg_write = 1'b0;
        #1;
        checks++;
        if (alu_inn1 !== 32'h10) begin
            failures++; $display("FAIL fwd_none got=%h exp=10", alu_inn1);
        end
    endtask

    task automatic test_reg_zero();
        id_rs = 5'd0; id_rs_data = 32'h0; id_rt = 5'd0; id_rt_data = 32'h0;
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hEE;
        step();
        checks++;
        if (alu_inn1 !== 32'h0 || ex_store_data !== 32'h0) begin
            failures++; $display("FAIL reg_zero got=%h/%h exp=0/0", alu_inn1, ex_store_data);
        end
        fwd_off();
    endtask

    task automatic test_alu_src_branch();
        id_rs = 5'd1; id_rs_data = 32'h5; id_rt = 5'd7; id_rt_data = 32'h1; id_rd = 5'd9;
        id_imm = 32'hFFFF_FFFC; id_pc4 = 32'h0000_0004;
        id_ctrl(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h55;
        step();
        checks++;
        if (alu_inn2 !== 32'hFFFF_FFFC || ex_store_data !== 32'h55) begin
            failures++; $display("FAIL alu_src got=%h/%h exp=fffffffc/55", alu_inn2, ex_store_data);
        end
        checks++;
        if (ex_branch_target !== 32'hFFFF_FFF4) begin
            failures++; $display("FAIL branch_target got=%h exp=fffffff4", ex_branch_target);
        end
        checks++;
        if (ex_write_reg !== 5'd7 || ex_rt !== 5'd7 || alu_funct !== 6'h3C || ex_branch !== 1'b1 || ex_mem_write !== 1'b1) begin
            failures++;
            $display("FAIL alu_src_ctrl got=%0d/%0d/%h/%0b/%0b exp=7/7/3c/1/1",
                     ex_write_reg, ex_rt, alu_funct, ex_branch, ex_mem_write);
        end
        fwd_off();
    endtask

    task automatic test_stall();
        id_rs = 5'd1; id_rs_data = 32'h111; id_rt = 5'd2; id_rt_data = 32'h222; id_rd = 5'd9;
        id_imm = 32'h0; id_pc4 = 32'h40;
        id_ctrl(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_rs = 5'(10 + i); id_rs_data = 32'h333 + i; id_rt = 5'd11; id_rt_data = 32'h444;
            id_rd = 5'd12; id_pc4 = 32'h80;
            id_ctrl(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            checks++;
            if (alu_inn1 !== 32'h111 || alu_inn2 !== 32'h222 || ex_write_reg !== 5'd9 ||
                ex_mem_read !== 1'b1 || alu_op !== 2'b01 || ex_branch_target !== 32'h40) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h/%h/%0d/%0b/%b/%h exp=111/222/9/1/01/40",
                         i, alu_inn1, alu_inn2, ex_write_reg, ex_mem_read, alu_op, ex_branch_target);
            end
        end
        mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'h999;
        #1;
        checks++;
        if (alu_inn1 !== 32'h999) begin
            failures++; $display("FAIL stall_fwd got=%h exp=999", alu_inn1);
        end
        fwd_off();
        stall = 1'b0;
        step();
        checks++;
        if (alu_inn1 !== 32'h335 || ex_write_reg !== 5'd11 || ex_reg_write !== 1'b1 ||
            ex_mem_read !== 1'b0 || ex_branch_target !== 32'h80) begin
            failures++;
            $display("FAIL stall_release got=%h/%0d/%0b/%0b/%h exp=335/11/1/0/80",
                     alu_inn1, ex_write_reg, ex_reg_write, ex_mem_read, ex_branch_target);
        end
    endtask

    task automatic test_flush_stall();
        id_rs = 5'd4; id_rs_data = 32'h77; id_imm = 32'h8; id_pc4 = 32'h10;
        id_ctrl(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; flush = 1'b1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || alu_op !== 2'b00) begin
            failures++;
            $display("FAIL flush_stall got=%0b/%0b/%0b/%b exp=0/0/0/00", ex_valid, ex_reg_write, ex_mem_write, alu_op);
        end
        checks++;
        if (alu_inn1 !== 32'h0 || ex_branch_target !== 32'h0) begin
            failures++; $display("FAIL flush_data got=%h/%h exp=0/0", alu_inn1, ex_branch_target);
        end
        stall = 1'b0; flush = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || alu_inn1 !== 32'h77 || ex_branch_target !== 32'h30) begin
            failures++;
            $display("FAIL back_to_back got=%0b/%0b/%h/%h exp=1/1/77/30", ex_valid, ex_reg_write, alu_inn1, ex_branch_target);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%0b/%0b/%0b exp=0/0/0", ex_valid, ex_reg_write, ex_mem_write);
        end
        reset = 1'b0; stall = 1'b0;
    endtask

    initial begin
        fwd_off();
        test_reset();
        test_fwd_priority();
        test_reg_zero();
        test_alu_src_branch();
        test_stall();
        test_flush_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
